// File: rtl/i2s_pkg.sv
// i2s_pkg: mode encodings and width helper shared by the I2S/TDM master
package i2s_pkg;
  localparam logic [1:0] MODE_I2S = 2'd0;
  localparam logic [1:0] MODE_LJ  = 2'd1;
  localparam logic [1:0] MODE_DSP = 2'd2;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/i2s_bclk_div.sv
// i2s_bclk_div: divides adc_clk down to bclk and strobes each bclk falling edge
module i2s_bclk_div import i2s_pkg::*; #(
  parameter int BCLK_DIV = 8
) (
  input  logic adc_clk,
  input  logic adc_rst,
  input  logic enable,
  output logic bclk,
  output logic fall,
  output logic start
);
  localparam int DW = clog2(BCLK_DIV);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          en_q;
  // the first enabled cycle counts as a falling edge so a frame starts at once
  always_comb begin
    start     = enable && !en_q;
    fall      = start || (enable && div_cnt_q == DW'(BCLK_DIV - 1));
    div_cnt_d = (!enable || fall) ? '0 : div_cnt_q + 1'b1;
    bclk_d    = 32'(div_cnt_d) >= BCLK_DIV / 2;
  end
  // divider state; held at zero while disabled
  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      en_q      <= enable;
    end
  end
  assign bclk = bclk_q;
endmodule

// File: rtl/i2s_tdm_master.sv
// i2s_tdm_master: I2S / left-justified / DSP TDM bus master serialising one frame per word clock
module i2s_tdm_master import i2s_pkg::*; #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int NUM_CH   = 2,
  parameter int BCLK_DIV = 8
) (
  input  logic                     adc_clk,
  input  logic                     adc_rst,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     i2s_bclk,
  output logic                     i2s_wclk,
  output logic                     i2s_sdo,
  output logic                     frame_start,
  output logic                     underrun
);
  localparam int FW = NUM_CH * DATA_W;
  localparam int BW = clog2(SLOT_W);
  localparam int SW = clog2(NUM_CH);
  localparam int IW = clog2(FW);
  logic          fall, start;
  logic [1:0]    mode_q, mode_d;
  logic          full_q, full_d;
  logic [FW-1:0] hold_q, hold_d, shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          wclk_q, wclk_d, sdo_q, sdo_d, dly_q, dly_d;
  logic          frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic          lj, dsp, accept, bit_last, slot_last, pos0, load, raw;
  logic [IW-1:0] idx;

  i2s_bclk_div #(.BCLK_DIV(BCLK_DIV)) u_div (
    .adc_clk (adc_clk),
    .adc_rst (adc_rst),
    .enable  (enable),
    .bclk    (i2s_bclk),
    .fall    (fall),
    .start   (start)
  );

  // position, handshake, frame load and serial data, all stepped on bclk falls
  always_comb begin
    lj            = mode_q == MODE_LJ;
    dsp           = mode_q == MODE_DSP;
    mode_d        = enable ? mode_q : mode;
    accept        = s_valid && !full_q;
    bit_last      = bit_q == BW'(SLOT_W - 1);
    slot_last     = slot_q == SW'(NUM_CH - 1);
    bit_d         = (!enable || start) ? '0 : !fall ? bit_q : bit_last ? '0 : bit_q + 1'b1;
    slot_d        = (!enable || start) ? '0 : (!fall || !bit_last) ? slot_q : slot_last ? '0 : slot_q + 1'b1;
    pos0          = bit_d == '0 && slot_d == '0;
    load          = fall && pos0;
    shift_d       = load ? (full_q ? hold_q : '0) : shift_q;
    hold_d        = accept ? s_data : hold_q;
    full_d        = accept || (full_q && !load);
    idx           = IW'(32'(slot_d) * DATA_W + DATA_W - 1 - 32'(bit_d));
    raw           = 32'(bit_d) < DATA_W && shift_d[idx];
    dly_d         = !enable ? 1'b0 : fall ? raw : dly_q;
    sdo_d         = !enable ? 1'b0 : fall ? (lj ? raw : dly_q) : sdo_q;
    wclk_d        = !enable ? 1'b0 : fall ? (dsp ? pos0 : 32'(slot_d) >= NUM_CH / 2) : wclk_q;
    frame_start_d = load;
    underrun_d    = load && !full_q;
  end

  // state register; asynchronous reset returns the bus to idle immediately
  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      mode_q        <= MODE_I2S;
      full_q        <= 1'b0;
      hold_q        <= '0;
      shift_q       <= '0;
      bit_q         <= '0;
      slot_q        <= '0;
      wclk_q        <= 1'b0;
      sdo_q         <= 1'b0;
      dly_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      full_q        <= full_d;
      hold_q        <= hold_d;
      shift_q       <= shift_d;
      bit_q         <= bit_d;
      slot_q        <= slot_d;
      wclk_q        <= wclk_d;
      sdo_q         <= sdo_d;
      dly_q         <= dly_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign s_ready     = !full_q;
  assign i2s_wclk    = wclk_q;
  assign i2s_sdo     = sdo_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_tdm_master.sv
// tb_i2s_tdm_master: directed checks of the I2S/TDM master in stereo and 8-slot DSP setups
module tb_i2s_tdm_master;
  logic         adc_clk = 1'b0, adc_rst = 1'b1;
  logic         enable = 1'b0, s_valid = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [47:0]  s_data = '0;
  logic         s_ready, i2s_bclk, i2s_wclk, i2s_sdo, frame_start, underrun;
  logic         enable2 = 1'b0, s_valid2 = 1'b0;
  logic [1:0]   mode2 = 2'd2;
  logic [191:0] s_data2 = '0;
  logic         s_ready2, bclk2, wclk2, sdo2, fs2, ur2;
  int           n_cmp = 0, n_bad = 0;
  int           idx, rdy;
  logic [63:0]  sv, wv;
  logic         ur, ok;
  logic [255:0] sv2, wv2, exp2;
  logic [23:0]  ch;

  localparam logic [47:0] A = {24'h7FFFFE, 24'h800001};
  localparam logic [47:0] B = {24'hF0F0F0, 24'h0A0A0A};
  localparam logic [47:0] D = {24'hFFFFFF, 24'h000001};
  localparam logic [47:0] E = {24'h123456, 24'h89ABCD};

  i2s_tdm_master dut (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .enable(enable), .mode(mode),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .i2s_bclk(i2s_bclk), .i2s_wclk(i2s_wclk), .i2s_sdo(i2s_sdo),
    .frame_start(frame_start), .underrun(underrun)
  );

  i2s_tdm_master #(.NUM_CH(8), .BCLK_DIV(2)) dut2 (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .enable(enable2), .mode(mode2),
    .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .i2s_bclk(bclk2), .i2s_wclk(wclk2), .i2s_sdo(sdo2),
    .frame_start(fs2), .underrun(ur2)
  );

  always #5 adc_clk = ~adc_clk;

  function automatic logic [63:0] f_i2s(input logic [47:0] d);
    return {1'b0, d[23:0], 8'h00, d[47:24], 7'h00};
  endfunction

  function automatic logic [63:0] f_lj(input logic [47:0] d);
    return {d[23:0], 8'h00, d[47:24], 8'h00};
  endfunction

  function automatic logic [47:0] bp(input int i);
    return {24'h5A5A00 + 24'(i), 24'hC30000 + 24'(i * 3)};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cap(output logic [63:0] s, output logic [63:0] w, output logic u, output logic k);
    int n = 0;
    while (!frame_start && n < 2000) begin
      @(negedge adc_clk);
      n++;
    end
    k = frame_start;
    u = underrun;
    s = '0;
    w = '0;
    for (int c = 0; c < 512; c++) begin
      if (c % 8 == 0 && i2s_bclk) k = 1'b0;
      if (c == 1 && frame_start) k = 1'b0;
      if (c % 8 == 4) begin
        if (!i2s_bclk) k = 1'b0;
        s[63 - c / 8] = i2s_sdo;
        w[63 - c / 8] = i2s_wclk;
      end
      @(negedge adc_clk);
    end
  endtask

  task automatic cap2(output logic [255:0] s, output logic [255:0] w, output logic k);
    int n = 0;
    while (!fs2 && n < 2000) begin
      @(negedge adc_clk);
      n++;
    end
    k = fs2;
    s = '0;
    w = '0;
    for (int c = 0; c < 512; c++) begin
      if (c % 2 == 0 && bclk2) k = 1'b0;
      if (c % 2 == 1) begin
        if (!bclk2) k = 1'b0;
        s[255 - c / 2] = sdo2;
        w[255 - c / 2] = wclk2;
      end
      @(negedge adc_clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge adc_clk);
    adc_rst = 1'b0;
    @(negedge adc_clk);
    chk("reset_state", {i2s_bclk, i2s_wclk, i2s_sdo, frame_start, underrun, s_ready,
                        bclk2, wclk2, sdo2, fs2, ur2, s_ready2}, 12'b000001_000001);
    s_data = A;
    s_valid = 1'b1;
    @(negedge adc_clk);
    s_valid = 1'b0;
    chk("idle_accept", {s_ready, i2s_bclk, frame_start}, 3'b000);
    enable = 1'b1;
    cap(sv, wv, ur, ok);
    chk("i2s_sdo", sv, f_i2s(A));
    chk("i2s_wclk", wv, {32'h0, 32'hFFFFFFFF});
    chk("i2s_ur", ur, 1'b0);
    chk("i2s_bclk", ok, 1'b1);
    cap(sv, wv, ur, ok);
    chk("ur_sdo", sv, 64'h0);
    chk("ur_pulse", {ur, ok}, 2'b11);
    repeat (511) @(negedge adc_clk);
    s_data = B;
    s_valid = 1'b1;
    @(negedge adc_clk);
    s_valid = 1'b0;
    chk("late_ur_on_load", {frame_start, underrun}, 2'b11);
    chk("late_held", s_ready, 1'b0);
    cap(sv, wv, ur, ok);
    chk("late_skip_sdo", sv, 64'h0);
    cap(sv, wv, ur, ok);
    chk("late_play_sdo", sv, f_i2s(B));
    chk("late_play_ur", ur, 1'b0);
    idx = 0;
    rdy = 0;
    fork
      begin
        s_valid = 1'b1;
        for (int c = 0; c < 2048; c++) begin
          if (s_ready) begin
            s_data = bp(idx);
            idx++;
            rdy++;
          end
          @(negedge adc_clk);
        end
        s_valid = 1'b0;
      end
      begin
        @(negedge adc_clk);
        for (int f = 0; f < 4; f++) begin
          cap(sv, wv, ur, ok);
          chk($sformatf("bp_sdo%0d", f), sv, f_i2s(bp(f)));
          chk($sformatf("bp_ur%0d", f), ur, 1'b0);
        end
      end
    join
    chk("bp_ready_cycles", rdy, 4);
    enable = 1'b0;
    mode = 2'd1;
    s_data = A;
    s_valid = 1'b1;
    @(negedge adc_clk);
    s_valid = 1'b0;
    enable = 1'b1;
    cap(sv, wv, ur, ok);
    chk("lj_sdo", sv, f_lj(A));
    chk("lj_wclk", wv, {32'h0, 32'hFFFFFFFF});
    chk("lj_bclk", ok, 1'b1);
    mode = 2'd0;
    s_data = B;
    s_valid = 1'b1;
    @(negedge adc_clk);
    s_valid = 1'b0;
    cap(sv, wv, ur, ok);
    chk("mode_hold_sdo", sv, f_lj(B));
    s_data = D;
    s_valid = 1'b1;
    @(negedge adc_clk);
    s_valid = 1'b0;
    repeat (511) @(negedge adc_clk);
    chk("drop_fs", frame_start, 1'b1);
    s_data = E;
    s_valid = 1'b1;
    @(negedge adc_clk);
    s_valid = 1'b0;
    repeat (323) @(negedge adc_clk);
    chk("pre_drop", {i2s_bclk, i2s_wclk, i2s_sdo}, 3'b111);
    enable = 1'b0;
    @(negedge adc_clk);
    chk("drop_outs", {i2s_bclk, i2s_wclk, i2s_sdo}, 3'b000);
    chk("drop_hold", s_ready, 1'b0);
    repeat (3) @(negedge adc_clk);
    enable = 1'b1;
    @(negedge adc_clk);
    chk("restart_fs", {frame_start, underrun}, 2'b10);
    cap(sv, wv, ur, ok);
    chk("restart_sdo", sv, f_i2s(E));
    chk("restart_wclk", wv, {32'h0, 32'hFFFFFFFF});
    s_data = A;
    s_valid = 1'b1;
    @(negedge adc_clk);
    s_valid = 1'b0;
    repeat (299) @(negedge adc_clk);
    chk("pre_rst", {i2s_bclk, i2s_wclk, s_ready}, 3'b110);
    #2 adc_rst = 1'b1;
    #1 chk("rst_async", {i2s_bclk, i2s_wclk, i2s_sdo, frame_start, underrun, s_ready}, 6'b000001);
    enable = 1'b0;
    @(negedge adc_clk);
    adc_rst = 1'b0;
    for (int k = 0; k < 8; k++) s_data2[k * 24 +: 24] = 24'h800001 + 24'(k) * 24'h010100;
    exp2 = '0;
    for (int k = 0; k < 8; k++) begin
      ch = s_data2[k * 24 +: 24];
      for (int j = 0; j < 24; j++) exp2[255 - (32 * k + 1 + j)] = ch[23 - j];
    end
    s_valid2 = 1'b1;
    @(negedge adc_clk);
    s_valid2 = 1'b0;
    enable2 = 1'b1;
    cap2(sv2, wv2, ok);
    chk("dsp_wclk", wv2, {1'b1, 255'h0});
    chk("dsp_sdo", sv2, exp2);
    chk("dsp_bclk", ok, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
